// File: rtl/btb_tag_ctrl.sv
// btb_tag_ctrl: BTB tag/valid RAM controller with lookup, queued updates and flush sweep.
// Define BTB_FLUSH_ON_RESET_EN to start a full flush sweep out of reset.
module btb_tag_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_fetch_pc,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  output logic        o_upd_ready,
  input  logic        i_flush,
  output logic [9:0]  o_ram_addr,
  output logic        o_ram_wren,
  output logic [22:0] o_ram_wdata,
  input  logic [22:0] i_rd_data,
  output logic        o_hit,
  output logic        o_pred_taken,
  output logic        o_busy
);
  localparam logic [1:0] LOOKUP = 2'd0, UPD_RD = 2'd1, UPD_WR = 2'd2, FLUSH = 2'd3;
  logic [1:0] state, state_nx, cnt, cnt_nx, ctr, ctr_nx;
  logic [30:0] q0, q1;
  logic [22:0] rdq;
  logic [9:0] sweep;
  logic pend, push, pop, to_flush, hit_u, look, slot0;
  logic unused;
  assign unused = ^{i_fetch_pc[1:0], i_upd_pc[1:0]};
  // FIFO entries hold {pc[31:2], taken}; q0 is always the head
  always_comb begin
    pop = state == UPD_WR;
    look = state == LOOKUP || i_reset;
    o_upd_ready = i_reset || (state != FLUSH && (cnt != 2'd2 || pop));
    push = i_upd_valid && o_upd_ready && !i_reset;
    cnt_nx = cnt + {1'b0, push} - {1'b0, pop};
    slot0 = cnt == 2'd0 || (cnt == 2'd1 && pop);
    to_flush = pend && (state == LOOKUP || pop);
    hit_u = rdq[22] && rdq[19:0] == q0[30:11];
    ctr = rdq[21:20];
    ctr_nx = q0[0] ? (ctr == 2'd3 ? ctr : ctr + 2'd1) : (ctr == 2'd0 ? ctr : ctr - 2'd1);
    o_ram_addr = look ? i_fetch_pc[11:2] : state == FLUSH ? sweep : q0[10:1];
    o_ram_wren = !i_reset && (state == FLUSH || (pop && (hit_u || q0[0])));
    o_ram_wdata = state == FLUSH ? 23'h0 : {1'b1, hit_u ? ctr_nx : 2'b10, q0[30:11]};
    o_hit = look && i_rd_data[22] && i_rd_data[19:0] == i_fetch_pc[31:12];
    o_pred_taken = o_hit && i_rd_data[21];
    o_busy = !i_reset && (state == FLUSH || pend);
    state_nx = to_flush ? FLUSH :
               state == LOOKUP ? (cnt != 2'd0 ? UPD_RD : LOOKUP) :
               state == UPD_RD ? UPD_WR :
               state == UPD_WR ? (cnt_nx != 2'd0 ? UPD_RD : LOOKUP) :
               (sweep == 10'd1023 && !i_flush ? LOOKUP : FLUSH);
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
`ifdef BTB_FLUSH_ON_RESET_EN
      state <= FLUSH;
`else
      state <= LOOKUP;
`endif
      cnt <= 2'd0;
      pend <= 1'b0;
      sweep <= 10'd0;
    end else begin
      state <= state_nx;
      cnt <= to_flush ? 2'd0 : cnt_nx;
      pend <= !to_flush && (pend || (i_flush && state != FLUSH));
      sweep <= (state == FLUSH && !i_flush) ? sweep + 10'd1 : 10'd0;
    end
  end
  always_ff @(posedge i_clk) begin
    if (state == UPD_RD) rdq <= i_rd_data;
    if (pop) q0 <= q1;
    if (push) begin
      if (slot0) q0 <= {i_upd_pc[31:2], i_upd_taken};
      else q1 <= {i_upd_pc[31:2], i_upd_taken};
    end
  end
endmodule

// File: tb/tb_btb_tag_ctrl.sv
// tb_btb_tag_ctrl: scoreboard bench for btb_tag_ctrl with a behavioural tag RAM.
module tb_btb_tag_ctrl;
  logic i_clk = 0, i_reset = 1, i_upd_valid = 0, i_upd_taken = 0, i_flush = 0;
  logic [31:0] i_fetch_pc = 0, i_upd_pc = 0;
  logic o_upd_ready, o_ram_wren, o_hit, o_pred_taken, o_busy;
  logic [9:0] o_ram_addr;
  logic [22:0] o_ram_wdata, i_rd_data;
  logic [22:0] mem [1024];
  logic look = 0;
  logic [32:0] wq [$];
  logic [1:0] lq [$];
  int n_tests = 0, n_fail = 0;

  btb_tag_ctrl dut (.i_clk(i_clk), .i_reset(i_reset), .i_fetch_pc(i_fetch_pc),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_taken(i_upd_taken),
    .o_upd_ready(o_upd_ready), .i_flush(i_flush), .o_ram_addr(o_ram_addr),
    .o_ram_wren(o_ram_wren), .o_ram_wdata(o_ram_wdata), .i_rd_data(i_rd_data),
    .o_hit(o_hit), .o_pred_taken(o_pred_taken), .o_busy(o_busy));

  always #5 i_clk = ~i_clk;
  initial for (int a = 0; a < 1024; a++) mem[a] = 23'h0;
  always @(posedge i_clk) if (o_ram_wren) mem[o_ram_addr] <= o_ram_wdata;
  assign i_rd_data = mem[o_ram_addr];

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: RAM writes and lookup results are checked against queued expectations
  always @(negedge i_clk) begin
    if (o_ram_wren) begin
      if (wq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", o_ram_addr, o_ram_wdata);
      end else chk("ram_write", {7'd0, o_ram_addr, o_ram_wdata}, {7'd0, wq.pop_front()});
    end
    if (look && lq.size() != 0) chk("lookup_hit_pred", {38'd0, o_hit, o_pred_taken}, {38'd0, lq.pop_front()});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic exp_wr(input logic [9:0] a, input logic [22:0] d);
    wq.push_back({a, d});
  endtask

  task automatic lookup(input logic [31:0] pc, input logic hit, input logic pred);
    i_fetch_pc = pc;
    lq.push_back({hit, pred});
    look = 1;
    tick;
    look = 0;
  endtask

  task automatic push_upd(input logic [31:0] pc, input logic tk);
    int k = 0;
    while (!o_upd_ready && k < 50) begin tick; k++; end
    i_upd_valid = 1;
    i_upd_pc = pc;
    i_upd_taken = tk;
    tick;
    i_upd_valid = 0;
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while (wq.size() != 0 && k < lim) begin tick; k++; end
    chk("drain_pending_writes", 40'(wq.size()), 40'd0);
    tick;
    tick;
  endtask

  initial begin
    @(negedge i_clk);
    chk("reset_wren", {39'd0, o_ram_wren}, 40'd0);
    chk("reset_busy", {39'd0, o_busy}, 40'd0);
    chk("reset_ready", {39'd0, o_upd_ready}, 40'd1);
    tick;
    i_reset = 0;
    @(negedge i_clk);
    chk("post_reset_busy", {39'd0, o_busy}, 40'd0);
    tick;
    lookup(32'h0000_1004, 0, 0);
    // allocate: {valid, 2'b10, tag 1}
    exp_wr(10'h001, 23'h600001);
    push_upd(32'h0000_1004, 1);
    drain(20);
    lookup(32'h0000_1004, 1, 1);
    lookup(32'h0000_2004, 0, 0);
    repeat (4) begin exp_wr(10'h001, 23'h700001); push_upd(32'h0000_1004, 1); drain(20); end
    exp_wr(10'h001, 23'h600001);
    push_upd(32'h0000_1004, 0);
    drain(20);
    exp_wr(10'h001, 23'h500001);
    push_upd(32'h0000_1004, 0);
    drain(20);
    lookup(32'h0000_1004, 1, 0);
    push_upd(32'h0000_3008, 0);
    repeat (6) tick;
    lookup(32'h0000_3008, 0, 0);
    // backpressure: third back-to-back push lands while FIFO is full
    exp_wr(10'h004, 23'h600004);
    exp_wr(10'h005, 23'h600005);
    i_upd_valid = 1;
    i_upd_taken = 1;
    i_upd_pc = 32'h0000_4010;
    tick;
    i_upd_pc = 32'h0000_5014;
    tick;
    i_upd_pc = 32'h0000_6018;
    @(negedge i_clk);
    chk("full_ready", {39'd0, o_upd_ready}, 40'd0);
    tick;
    i_upd_valid = 0;
    drain(20);
    lookup(32'h0000_6018, 0, 0);
    lookup(32'h0000_5014, 1, 1);
    // flush raised in UPD_RD: pending update completes first
    exp_wr(10'h008, 23'h600007);
    for (int a = 0; a < 1024; a++) exp_wr(a[9:0], 23'h0);
    push_upd(32'h0000_7020, 1);
    tick;
    i_flush = 1;
    tick;
    i_flush = 0;
    @(negedge i_clk);
    chk("flush_busy", {39'd0, o_busy}, 40'd1);
    tick;
    chk("flush_ready_low", {39'd0, o_upd_ready}, 40'd0);
    drain(2000);
    chk("after_flush_busy", {39'd0, o_busy}, 40'd0);
    lookup(32'h0000_1004, 0, 0);
    lookup(32'h0000_7020, 0, 0);
    // reset while the sweep is at address 500
    for (int a = 0; a < 500; a++) exp_wr(a[9:0], 23'h0);
    i_flush = 1;
    tick;
    i_flush = 0;
    chk("pend_busy", {39'd0, o_busy}, 40'd1);
    repeat (501) tick;
    i_reset = 1;
    @(negedge i_clk);
    chk("mid_flush_reset_wren", {39'd0, o_ram_wren}, 40'd0);
    tick;
    i_reset = 0;
    chk("sweep_writes_before_reset", 40'(wq.size()), 40'd0);
    @(negedge i_clk);
    chk("after_abort_busy", {39'd0, o_busy}, 40'd0);
    chk("after_abort_ready", {39'd0, o_upd_ready}, 40'd1);
    tick;
    exp_wr(10'h009, 23'h600009);
    push_upd(32'h0000_9024, 1);
    drain(20);
    lookup(32'h0000_9024, 1, 1);
    repeat (3) tick;
    chk("lookup_queue_empty", 40'(lq.size()), 40'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
